// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared scan-code constants, key indices and prefix FSM encoding for the
// PS/2 key event path.
package ps2_pkg;

  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_NULL   = 8'h00;

  localparam logic [1:0] KEY_SPACE = 2'd0;
  localparam logic [1:0] KEY_ENTER = 2'd1;
  localparam logic [1:0] KEY_ESC   = 2'd2;
  localparam logic [1:0] KEY_UP    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_e;

  // Bytes that carry no key information and must not disturb a prefix sequence.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_NULL) || (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND);
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_key_map.sv
// Combinational scan-code to game-key lookup; extended and non-extended
// codes live in separate namespaces.
module ps2_key_map
  import ps2_pkg::*;
(
  input  logic [7:0] code_byte,
  input  logic       ext,
  output logic       hit,
  output logic [1:0] key_idx
);

  always_comb begin
    hit     = 1'b0;
    key_idx = '0;
    if (!ext) begin
      case (code_byte)
        SC_SPACE: begin hit = 1'b1; key_idx = KEY_SPACE; end
        SC_ENTER: begin hit = 1'b1; key_idx = KEY_ENTER; end
        SC_ESC:   begin hit = 1'b1; key_idx = KEY_ESC;   end
        default:  ;
      endcase
    end else begin
      if (code_byte == SC_UP) begin
        hit     = 1'b1;
        key_idx = KEY_UP;
      end
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Resolves E0/F0 prefixes into make/break events, tracks held keys and emits
// one-cycle press/release strobes with auto-repeat filtered out.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 2_500_000,
  parameter int unsigned CNT_W          = 22
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] code_byte,
  output logic [3:0] key_held,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic       seq_error
);

  ps2_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_held, r_press, r_release;
  logic             r_seq_error;

  logic             w_accept;
  logic             w_make, w_break, w_err;
  logic             w_ext;
  logic             w_hit;
  logic [1:0]       w_idx;

  assign w_accept = code_valid && !is_ignored(code_byte);
  assign w_ext    = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);

  ps2_key_map u_key_map (
    .code_byte (code_byte),
    .ext       (w_ext),
    .hit       (w_hit),
    .key_idx   (w_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_state == ST_IDLE) ? '0 : r_cnt + CNT_W'(1);
    w_make      = 1'b0;
    w_break     = 1'b0;
    w_err       = 1'b0;
    // An accepted byte takes priority over an expiry in the same cycle.
    if (w_accept) begin
      w_cnt_nxt = '0;
      case (r_state)
        ST_IDLE: begin
          if (code_byte == SC_EXT)      w_state_nxt = ST_EXT;
          else if (code_byte == SC_BRK) w_state_nxt = ST_BRK;
          else                          w_make      = 1'b1;
        end
        ST_EXT: begin
          if (code_byte == SC_BRK)      w_state_nxt = ST_EXT_BRK;
          else if (code_byte == SC_EXT) w_err       = 1'b1;
          else begin
            w_make      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          if (code_byte == SC_EXT || code_byte == SC_BRK) w_err   = 1'b1;
          else                                            w_break = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && r_cnt == CNT_W'(PREFIX_TIMEOUT - 1)) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_err       = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_held      <= '0;
      r_press     <= '0;
      r_release   <= '0;
      r_seq_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_press     <= '0;
      r_release   <= '0;
      r_seq_error <= w_err;
      if (w_make && w_hit && !r_held[w_idx]) begin
        r_held[w_idx]  <= 1'b1;
        r_press[w_idx] <= 1'b1;
      end
      if (w_break && w_hit && r_held[w_idx]) begin
        r_held[w_idx]    <= 1'b0;
        r_release[w_idx] <= 1'b1;
      end
    end
  end

  assign key_held    = r_held;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign seq_error   = r_seq_error;

endmodule
